tdm_demux: RTL

- Sequential receive end of a time-division-multiplexed link. A transmitter walks a mux select across NCH channels and emits one WIDTH-bit word per valid beat, with the start of each frame flagged.
- This block tracks the slot, fans each word out to its channel, and commits a complete frame to the outputs atomically.
- Sits downstream of mux2to1-style serialisers; it is the reassembly point for every channel bus in the combinational library.

---
 rtl/tdm_demux.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a TDM link.
// Words arrive one per valid beat, channel 0 first (flagged by in_sof).
// They are collected in a shadow buffer, and a complete frame is committed
// to y in one step, so y never mixes two frames.
// The slot counter sel tracks the channel expected for the next word.
//
// Optional feature, macro TDM_PARITY_EN:
//   - adds the in_par input, the even parity of d on each valid beat;
//   - a frame with any bad word is aborted (frame_err) instead of committed.
//
// Handshake: there is no ready.
//   - A word is consumed on every rising edge where in_valid=1.
//   - in_sof is only meaningful when in_valid=1.
//
// FSM state is visible on busy (1 = RECV, 0 = IDLE).
module tdm_demux #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [WIDTH-1:0]       d,
`ifdef TDM_PARITY_EN
  input  logic                   in_par,
`endif
  output logic [NCH*WIDTH-1:0]   y,
  output logic [$clog2(NCH)-1:0] sel,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam int CW = $clog2(NCH);
  localparam int SW = (NCH - 1) * WIDTH;
  localparam logic [CW-1:0] LAST_SLOT = CW'(NCH - 1);
  localparam logic [CW-1:0] ONE_SLOT  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // The last slot is never stored: it comes straight from d at commit time.
  // The shadow buffer therefore only holds slots 0..NCH-2.
  state_t                 state_q, state_d;
  logic [CW-1:0]          sel_q, sel_d;
  logic [SW-1:0]          shadow_q, shadow_d;
  logic [NCH*WIDTH-1:0]   y_q, y_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  // High when the frame ending on this beat must be aborted, not committed.
  logic                   frame_bad;

`ifdef TDM_PARITY_EN
  logic word_bad;
  logic par_flag_q, par_flag_d;

  assign word_bad = in_valid && (in_par != (^d));

  // Parity flag update.
  //   - Any accepted sof restarts the flag with that word's own check.
  //   - The flag accumulates across the middle words of the frame.
  //   - It clears at the last slot, whether the frame commits or aborts.
  always_comb begin
    par_flag_d = par_flag_q;
    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (in_sof) par_flag_d = word_bad;
        end
        RECV: begin
          if (in_sof)                  par_flag_d = word_bad;
          else if (sel_q == LAST_SLOT) par_flag_d = 1'b0;
          else                         par_flag_d = par_flag_q | word_bad;
        end
        default: par_flag_d = 1'b0;
      endcase
    end
  end

  // Parity flag register.
  always_ff @(posedge clk) begin
    if (rst) par_flag_q <= 1'b0;
    else     par_flag_q <= par_flag_d;
  end

  // The current word's own check counts too, so a bad last word still aborts.
  assign frame_bad = par_flag_q | word_bad;
`else
  assign frame_bad = 1'b0;
`endif

  // Next-state, slot counter, shadow writes and commit/abort decisions.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Only a sof beat opens a frame; other valid beats are dropped.
        if (in_valid && in_sof) begin
          shadow_d[0 +: WIDTH] = d;
          sel_d                = ONE_SLOT;
          state_d              = RECV;
        end
      end

      RECV: begin
        if (in_valid) begin
          if (in_sof) begin
            // Resync.
            //   - Discard the partial frame and restart on this word.
            //   - This is checked ahead of the last-slot case, so a sof on
            //     the last slot is a resync, not a commit.
            err_d                = 1'b1;
            shadow_d[0 +: WIDTH] = d;
            sel_d                = ONE_SLOT;
          end else if (sel_q == LAST_SLOT) begin
            // Last word: commit the whole frame at once, or abort it if the
            // frame is marked bad.
            if (frame_bad) begin
              err_d  = 1'b1;
            end else begin
              y_d    = {d, shadow_q};
              done_d = 1'b1;
            end
            sel_d   = '0;
            state_d = IDLE;
          end else begin
            shadow_d[int'(sel_q) * WIDTH +: WIDTH] = d;
            sel_d = sel_q + ONE_SLOT;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // State and datapath registers.
  //   - rst overrides every input.
  //   - A reset mid-frame drops the partial frame without raising frame_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign y          = y_q;
  assign sel        = sel_q;
  assign busy       = (state_q == RECV);
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule
